// File: rtl/cheshire_uart_tx_pkg.sv
// Shared types and constants for the Cheshire UART transmitter.
package cheshire_uart_tx_pkg;

    localparam int unsigned UartDataBits = 8;
    localparam int unsigned UartDivWidth = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_e;

    // Frame settings captured when a byte is popped; div is already clamped to >= 1.
    typedef struct packed {
        logic [UartDivWidth-1:0] div;
        logic                    parity_en;
        logic                    parity_odd;
        logic                    stop2;
    } uart_tx_cfg_t;

endpackage

// File: rtl/cheshire_uart_tx_fifo.sv
// Byte FIFO with the fifo_v3 port set (non-fall-through); head entry is read combinationally.
module cheshire_uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          flush_i,
    output logic                                          full_o,
    output logic                                          empty_o,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0]  usage_o,
    input  logic [DATA_WIDTH-1:0]                         data_i,
    input  logic                                          push_i,
    output logic [DATA_WIDTH-1:0]                         data_o,
    input  logic                                          pop_i
);

    localparam int unsigned AddrDepth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AddrDepth-1:0]  rd_ptr;
    logic [AddrDepth-1:0]  wr_ptr;
    logic [AddrDepth:0]    count;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count == (AddrDepth+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign usage_o = count[AddrDepth-1:0];
    assign data_o  = mem[rd_ptr];

    // A full FIFO never takes a push, even when a pop happens on the same edge.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AddrDepth'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AddrDepth'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AddrDepth+1)'(1);
                2'b01:   count <= count - (AddrDepth+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/cheshire_uart_tx.sv
// UART transmitter: valid/ready byte stream into a FIFO, serialized LSB-first
// with optional parity and one or two stop bits; bit time set in clock cycles.
//
// state     | meaning
// ST_IDLE   | line high, waiting for a buffered byte
// ST_START  | start bit (low) for one bit time
// ST_DATA   | data bits 0..7, LSB first
// ST_PARITY | parity bit (only when enabled)
// ST_STOP   | line high for one or two bit times
module cheshire_uart_tx
    import cheshire_uart_tx_pkg::*;
#(
    parameter int unsigned DivWidth  = 16,
    parameter int unsigned FifoDepth = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [DivWidth-1:0]            cfg_div_i,
    input  logic                           cfg_parity_en_i,
    input  logic                           cfg_parity_odd_i,
    input  logic                           cfg_stop2_i,
    input  logic [UartDataBits-1:0]        data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic                           uart_tx_o,
    output logic                           busy_o,
    output logic                           tx_done_o,
    output logic [$clog2(FifoDepth+1)-1:0] fifo_level_o
);

    localparam int unsigned LevelWidth = $clog2(FifoDepth + 1);
    localparam int unsigned UsageWidth = $clog2(FifoDepth);

    uart_tx_state_e          state_q, state_d;
    uart_tx_cfg_t            cfg_q, cfg_d;
    logic [DivWidth-1:0]     timer_q, timer_d;
    logic [2:0]              idx_q, idx_d;
    logic [UartDataBits-1:0] shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    tx_q, tx_d;
    logic                    done_q, done_d;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [UsageWidth-1:0]   fifo_usage;
    logic [UartDataBits-1:0] fifo_data;
    logic                    fifo_push;
    logic                    fifo_pop;

    logic [DivWidth-1:0]     div_eff;
    logic [DivWidth-1:0]     reload;
    logic                    tick;
    logic                    start_frame;

    assign ready_o      = ~fifo_full & ~rst_i;
    assign fifo_push    = valid_i & ready_o;
    assign fifo_level_o = fifo_full ? LevelWidth'(FifoDepth) : LevelWidth'(fifo_usage);

    cheshire_uart_tx_fifo #(
        .DATA_WIDTH (UartDataBits),
        .DEPTH      (FifoDepth)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (~rst_i),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (data_i),
        .push_i  (fifo_push),
        .data_o  (fifo_data),
        .pop_i   (fifo_pop)
    );

    assign div_eff = (cfg_div_i == '0) ? DivWidth'(1) : cfg_div_i;
    assign reload  = DivWidth'(cfg_q.div) - DivWidth'(1);
    assign tick    = (timer_q == '0);

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tx_d        = tx_q;
        done_d      = 1'b0;
        start_frame = 1'b0;

        if (state_q != ST_IDLE && !tick) timer_d = timer_q - DivWidth'(1);

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) start_frame = 1'b1;
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    timer_d = reload;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    timer_d = reload;
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
                        if (cfg_q.parity_en) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q ^ cfg_q.parity_odd;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    idx_d   = 3'd0;
                    tx_d    = 1'b1;
                    timer_d = reload;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (cfg_q.stop2 && idx_q == 3'd0) begin
                        idx_d   = 3'd1;
                        timer_d = reload;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        if (!fifo_empty) start_frame = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Popping and entering START share the edge so back-to-back frames have no gap.
        if (start_frame) begin
            state_d          = ST_START;
            tx_d             = 1'b0;
            timer_d          = div_eff - DivWidth'(1);
            shift_d          = fifo_data;
            par_d            = ^fifo_data;
            cfg_d.div        = UartDivWidth'(div_eff);
            cfg_d.parity_en  = cfg_parity_en_i;
            cfg_d.parity_odd = cfg_parity_odd_i;
            cfg_d.stop2      = cfg_stop2_i;
        end
    end

    assign fifo_pop = start_frame;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign uart_tx_o = tx_q;
    assign tx_done_o = done_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cheshire_uart_tx.sv
// Scoreboard bench for cheshire_uart_tx: stimulus queues expected frames, a line monitor checks them.
module tb_cheshire_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_div;
    logic        cfg_parity_en;
    logic        cfg_parity_odd;
    logic        cfg_stop2;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        tx;
    logic        busy;
    logic        done;
    logic [3:0]  level;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         pe;
        bit         par;
        bit         s2;
        bit         gap0;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   in_frame = 1'b0;
    int   idle_cnt = 0;

    always #5 clk = ~clk;

    cheshire_uart_tx dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_div_i        (cfg_div),
        .cfg_parity_en_i  (cfg_parity_en),
        .cfg_parity_odd_i (cfg_parity_odd),
        .cfg_stop2_i      (cfg_stop2),
        .data_i           (data),
        .valid_i          (valid),
        .ready_o          (ready),
        .uart_tx_o        (tx),
        .busy_o           (busy),
        .tx_done_o        (done),
        .fifo_level_o     (level)
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic push(input logic [7:0] b, input int d, input bit pe, input bit par,
                        input bit s2, input bit gap0, output int stalls);
        exp_t e;
        int   n = 0;
        data  = b;
        valid = 1'b1;
        while (ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        stalls = n;
        if (n >= 5000) begin
            chk($sformatf("push_timeout_%02h", b), int'(ready), 1);
            valid = 1'b0;
            return;
        end
        e.data = b; e.div = d; e.pe = pe; e.par = par; e.s2 = s2; e.gap0 = gap0;
        exp_q.push_back(e);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || in_frame || busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) chk({name, "_idle_timeout"}, int'(busy), 0);
        repeat (3) @(negedge clk);
        chk({name, "_busy_low"}, int'(busy), 0);
        chk({name, "_level_zero"}, int'(level), 0);
    endtask

    // Line monitor: decodes each frame cycle-exactly against the next expected entry.
    initial begin
        exp_t        cur;
        logic [11:0] bits;
        logic [11:0] sh;
        int          c;
        int          len;
        int          bad;
        bit          expect_done;
        c = 0; len = 0; bad = 0; expect_done = 1'b0; bits = '0;
        cur.data = 8'h00; cur.div = 1; cur.pe = 0; cur.par = 0; cur.s2 = 0; cur.gap0 = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                in_frame    = 1'b0;
                expect_done = 1'b0;
                idle_cnt    = 0;
                continue;
            end
            if (expect_done) begin
                chk($sformatf("done_pulse_%02h", cur.data), int'(done), 1);
                expect_done = 1'b0;
            end
            if (!in_frame) begin
                if (tx === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_start_bit", int'(tx), 1);
                    end else begin
                        cur  = exp_q.pop_front();
                        bits = {3'b111, cur.data, 1'b0};
                        if (cur.pe) bits[9] = cur.par;
                        len  = cur.div * (10 + int'(cur.pe) + int'(cur.s2));
                        if (cur.gap0) chk($sformatf("gap_before_%02h", cur.data), idle_cnt, 0);
                        in_frame = 1'b1;
                        c   = 0;
                        bad = 0;
                    end
                end else begin
                    idle_cnt++;
                end
            end
            if (in_frame) begin
                sh = bits >> (c / cur.div);
                if (tx !== sh[0]) bad++;
                if (c > 0 && done !== 1'b0) bad++;
                c++;
                if (c == len) begin
                    chk($sformatf("frame_%02h_bad_cycles", cur.data), bad, 0);
                    in_frame    = 1'b0;
                    idle_cnt    = 0;
                    expect_done = 1'b1;
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        chk("watchdog_expired", 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int st;
        int bad;
        rst = 1'b1; valid = 1'b0; data = 8'h00;
        cfg_div = 16'd4; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_high", int'(tx), 1);
        chk("rst_ready_low", int'(ready), 0);
        chk("rst_busy_low", int'(busy), 0);
        chk("rst_done_low", int'(done), 0);
        chk("rst_level_zero", int'(level), 0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", int'(ready), 1);

        // D=4, 8N1, 0x55: line falls one edge after the accept.
        push(8'h55, 4, 0, 0, 0, 0, st);
        chk("t1_line_high_after_accept", int'(tx), 1);
        @(negedge clk);
        chk("t1_line_low_next_edge", int'(tx), 0);
        chk("t1_busy_in_frame", int'(busy), 1);
        wait_idle("t1");

        // D=3, 0x07 has three ones: even parity bit 1, odd parity bit 0.
        cfg_div = 16'd3; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
        push(8'h07, 3, 1, 1, 0, 0, st);
        wait_idle("t2_even");
        cfg_parity_odd = 1'b1;
        push(8'h07, 3, 1, 0, 0, 0, st);
        wait_idle("t2_odd");

        // D=2, two stop bits, back-to-back 0xA0 then 0x0F.
        cfg_div = 16'd2; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b1;
        push(8'hA0, 2, 0, 0, 1, 0, st);
        push(8'h0F, 2, 0, 0, 1, 1, st);
        wait_idle("t3");

        // D=100, ten bytes: nine fit, the tenth waits for the second pop.
        cfg_div = 16'd100; cfg_stop2 = 1'b0;
        push(8'h01, 100, 0, 0, 0, 0, st);
        for (int i = 2; i <= 9; i++) push(8'(i), 100, 0, 0, 0, 1, st);
        chk("t4_level_full", int'(level), 8);
        chk("t4_ready_low_full", int'(ready), 0);
        push(8'h0A, 100, 0, 0, 0, 1, st);
        chk("t4_byte10_stall_cycles", st, 993);
        wait_idle("t4");

        // D=4 frame with div changed to 8 during data bit 2; only the next frame uses 8.
        cfg_div = 16'd4;
        push(8'h3C, 4, 0, 0, 0, 0, st);
        push(8'hC3, 8, 0, 0, 0, 1, st);
        repeat (13) @(negedge clk);
        cfg_div = 16'd8;
        wait_idle("t5");
        cfg_div = 16'd4;

        // Reset during data bit 3 with three bytes queued.
        push(8'h11, 4, 0, 0, 0, 0, st);
        push(8'h22, 4, 0, 0, 0, 1, st);
        push(8'h33, 4, 0, 0, 0, 1, st);
        push(8'h44, 4, 0, 0, 0, 1, st);
        chk("t6_level_before_rst", int'(level), 3);
        repeat (15) @(negedge clk);
        chk("t6_line_low_bit3_of_0x11", int'(tx), 0);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_tx_high_async", int'(tx), 1);
        chk("t6_level_cleared", int'(level), 0);
        chk("t6_ready_low_in_rst", int'(ready), 0);
        chk("t6_busy_low_in_rst", int'(busy), 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        chk("t6_line_idle_after_release", bad, 0);
        chk("t6_level_after_release", int'(level), 0);
        chk("t6_busy_after_release", int'(busy), 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
